arbitro_perfil_seq: RTL
=======================

# arbitro_perfil_seq

Sequential, parametrised arbiter for N input entities (IEs), each presenting a profile code, a function code and a request button. It latches requests, grants one IE at a time by profile priority for a fixed hold window, drops lower-priority requests for the same function, and flags invalid profiles. It sits between the switch/button front end and the LED, matrix, 7-segment and RGB output decoders, and generalises the two-IE combinational priority path to N channels with timed grants.

## Interface
- N_IE, 2, number of input entities (≥2)
- PERF_W, 3, profile code width; higher value = higher priority; 0 = invalid
- FUN_W, 3, function code width
- HOLD_CYC, 8, grant hold length in cycles (≥1)
- IDX_W, max(1, clog2(N_IE)), derived; grant index width

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- PERF  in  N_IE*PERF_W  profile of IE i at [i*PERF_W +: PERF_W]
- FUN  in  N_IE*FUN_W  function of IE i at [i*FUN_W +: FUN_W]
- REQ  in  N_IE  request level per IE (already synchronised/debounced upstream)
- GNT  out  N_IE  one-hot grant, all-zero when idle
- GNT_IDX  out  IDX_W  index of granted IE
- GNT_FUN  out  FUN_W  function of granted IE (to LED/matrix decoders)
- GNT_PERF  out  PERF_W  profile of granted IE (to 7-segment decoder)
- BUSY  out  1  grant active
- CONFLITO  out  1  one-cycle pulse: request(s) dropped for function clash
- ERRO_PERF  out  1  registered: some IE currently presents PERF = 0 (RGB red)

## Operation
- Edge detect: REQ_q register per IE; rise = REQ & ~REQ_q. Rise with PERF ≠ 0 sets PEND[i]; rise with PERF = 0 is discarded.
- FSM states: OCIOSO, CONCEDE, PAUSA.
- OCIOSO: if any PEND, pick winner = highest PERF among pending; tie → lowest index. On that edge: register GNT/GNT_IDX/GNT_FUN/GNT_PERF from the winner's current inputs, clear PEND[winner], load counter = HOLD_CYC-1, go CONCEDE.
- Conflict: at the same edge, every other pending IE with FUN equal to the winner's is dropped (PEND cleared); CONFLITO = 1 for exactly that cycle if ≥1 dropped.
- CONCEDE: BUSY = 1, outputs held (later PERF/FUN changes ignored); counter decrements; at 0 → PAUSA.
- PAUSA: one cycle, GNT/GNT_IDX/GNT_FUN/GNT_PERF/BUSY = 0; → OCIOSO.
- New rises are accepted in every state, including from the granted IE (re-queued).
- Same-edge set and clear of PEND[i]: set wins.
- ERRO_PERF registered each cycle from OR over IEs of (PERF == 0), independent of FSM.

## Timing
- Reset (async assert, all regs): state OCIOSO, PEND = 0, REQ_q = 0, counter = 0, all outputs 0. REQ already high at reset release counts as one rise.
- REQ rises before edge k → PEND set at k → grant visible after edge k+1 (2-cycle latency from idle).
- Grant length exactly HOLD_CYC cycles BUSY high, then exactly 1 idle cycle; back-to-back grants spaced HOLD_CYC+1 cycles.
- RST mid-grant: outputs clear immediately (asynchronous), pending requests lost.
- HOLD_CYC = 1: one BUSY cycle, counter loaded 0.

## Configuration
- ARBITRO_ENVELHECIMENTO_EN defined: each pending IE has a 2-bit saturating age counter, incremented each time another IE wins while it stays pending, cleared on its grant, drop or reset. IEs with age = 3 outrank all others; among aged IEs lowest index wins. Conflict drop applies unchanged.
- Undefined: no age counters; pure profile priority (starvation possible).

## Test plan
- Reset: RST pulse with REQ = 0 → all outputs 0, no grant in following 10 cycles.
- Single request, N_IE=2, HOLD_CYC=4: IE0 PERF=5 FUN=2 REQ rise → GNT=01, GNT_PERF=5, GNT_FUN=2 two cycles later, BUSY high 4 cycles, 1 cycle all-zero.
- Priority: same-cycle rises IE0 PERF=2 FUN=1, IE1 PERF=6 FUN=4 → IE1 granted first, IE0 after gap; repeat with both PERF=4 → IE0 first.
- Conflict: IE0 PERF=6 FUN=3, IE1 PERF=2 FUN=3 same cycle → IE0 granted, CONFLITO one-cycle pulse at grant edge, IE1 never granted.
- Invalid profile: IE1 PERF=0 REQ rise → no grant, ERRO_PERF=1 one cycle after PERF=0 applied, 0 after PERF=3.
- Aging (macro defined, N_IE=3): IE2 PERF=1 pending while IE0/IE1 PERF=7 re-request continuously → IE2 granted no later than its 4th arbitration; RST mid-grant clears GNT immediately.

Source files
------------

// File: rtl/arbitro_perfil_seq.sv
// arbitro_perfil_seq
// -----------------------------------------------------------------------------
// Sequential profile-priority arbiter for N_IE input entities (IEs).
// Each IE presents a profile code (higher = more important, 0 = invalid),
// a function code and a request level. Rising edges of REQ with a valid
// profile are latched as pending. One IE at a time is granted for HOLD_CYC
// cycles, followed by one idle cycle. When a grant is issued, every other
// pending IE asking for the same function is dropped, and CONFLITO pulses.
//
// Handshake: REQ is a level. Only its rising edge counts as a request. The
// arbiter never acknowledges per request. A request is served when GNT shows
// that IE one-hot with BUSY high. A request can be lost to a function clash
// or a reset. A requester that wants a new grant must drop REQ and raise it
// again. It may do so at any time, including during its own grant.
//
// Optional feature (macro ARBITRO_ENVELHECIMENTO_EN): a 2-bit saturating age
// per pending IE. The age counts the grants won by other IEs while that IE
// stays pending. An IE of age 3 outranks any profile, and the lowest such
// index wins. Without the macro, priority depends on profile only.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   PERF       profile of IE i at [i*PERF_W +: PERF_W]
//   FUN        function of IE i at [i*FUN_W +: FUN_W]
//   REQ        request level per IE
//   GNT        one-hot grant, zero when idle
//   GNT_IDX    index of granted IE
//   GNT_FUN    function of granted IE, captured at grant
//   GNT_PERF   profile of granted IE, captured at grant
//   BUSY       grant active
//   CONFLITO   one-cycle pulse: pending request(s) dropped for a function clash
//   ERRO_PERF  registered: some IE presents PERF = 0
//   dbg_state  current FSM state (0 idle, 1 grant, 2 pause)
// -----------------------------------------------------------------------------
module arbitro_perfil_seq #(
  parameter int N_IE     = 2,
  parameter int PERF_W   = 3,
  parameter int FUN_W    = 3,
  parameter int HOLD_CYC = 8,
  parameter int IDX_W    = (N_IE > 1) ? $clog2(N_IE) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_IE*PERF_W-1:0]   PERF,
  input  logic [N_IE*FUN_W-1:0]    FUN,
  input  logic [N_IE-1:0]          REQ,
  output logic [N_IE-1:0]          GNT,
  output logic [IDX_W-1:0]         GNT_IDX,
  output logic [FUN_W-1:0]         GNT_FUN,
  output logic [PERF_W-1:0]        GNT_PERF,
  output logic                     BUSY,
  output logic                     CONFLITO,
  output logic                     ERRO_PERF,
  output logic [1:0]               dbg_state
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CONCEDE = 2'd1,
    PAUSA   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [N_IE-1:0]   req_q, pend, pend_nxt;
  logic [N_IE-1:0]   rise, nz, aged, win_oh, drop;
  logic              found, arb;
  logic [IDX_W-1:0]  win;
  logic [PERF_W-1:0] best, win_perf;
  logic [FUN_W-1:0]  win_fun;

  assign dbg_state = state;

`ifdef ARBITRO_ENVELHECIMENTO_EN
  logic [1:0] age [N_IE];

  always_comb begin
    for (int i = 0; i < N_IE; i++) aged[i] = pend[i] && (age[i] == 2'd3);
  end

  // Age counts grants lost while still pending. Leaving pending (grant or
  // drop) always restarts it, so a fresh request starts at zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_IE; i++) age[i] <= 2'd0;
    end else begin
      for (int i = 0; i < N_IE; i++) begin
        if (win_oh[i] || drop[i])
          age[i] <= 2'd0;
        else if (arb && pend[i] && (age[i] != 2'd3))
          age[i] <= age[i] + 2'd1;
      end
    end
  end
`else
  assign aged = '0;
`endif

  // Winner selection and pending bookkeeping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    best  = '0;
    for (int i = 0; i < N_IE; i++) begin
      nz[i] = |PERF[i*PERF_W +: PERF_W];
    end
    rise = REQ & ~req_q;

    // Strict '>' while scanning upward keeps the lowest index on a tie.
    for (int i = 0; i < N_IE; i++) begin
      if (pend[i] && (!found || (PERF[i*PERF_W +: PERF_W] > best))) begin
        found = 1'b1;
        win   = IDX_W'(i);
        best  = PERF[i*PERF_W +: PERF_W];
      end
    end
    // Aged IEs override the profile order. A downward scan leaves the lowest index.
    if (|aged) begin
      for (int i = N_IE - 1; i >= 0; i--) begin
        if (aged[i]) win = IDX_W'(i);
      end
    end

    win_perf = PERF[win*PERF_W +: PERF_W];
    win_fun  = FUN[win*FUN_W +: FUN_W];

    // The pause cycle also arbitrates. This keeps the idle gap between
    // back-to-back grants at exactly one cycle.
    arb = found && (state != CONCEDE);

    for (int i = 0; i < N_IE; i++) begin
      win_oh[i] = arb && (win == IDX_W'(i));
      drop[i]   = arb && pend[i] && (win != IDX_W'(i)) &&
                  (FUN[i*FUN_W +: FUN_W] == win_fun);
    end

    // A rise on the same edge as a clear wins, so the request is re-queued.
    pend_nxt = (pend & ~(win_oh | drop)) | (rise & nz);
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      OCIOSO, PAUSA: begin
        if (arb) begin
          state_nxt = CONCEDE;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = OCIOSO;
        end
      end
      CONCEDE: begin
        if (cnt == '0) state_nxt = PAUSA;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= OCIOSO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request latch and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_q     <= '0;
      pend      <= '0;
      GNT       <= '0;
      GNT_IDX   <= '0;
      GNT_FUN   <= '0;
      GNT_PERF  <= '0;
      BUSY      <= 1'b0;
      CONFLITO  <= 1'b0;
      ERRO_PERF <= 1'b0;
    end else begin
      req_q     <= REQ;
      pend      <= pend_nxt;
      CONFLITO  <= |drop;
      ERRO_PERF <= ~&nz;
      if (arb) begin
        GNT      <= win_oh;
        GNT_IDX  <= win;
        GNT_FUN  <= win_fun;
        GNT_PERF <= win_perf;
        BUSY     <= 1'b1;
      end else if ((state == CONCEDE) && (cnt == '0)) begin
        GNT      <= '0;
        GNT_IDX  <= '0;
        GNT_FUN  <= '0;
        GNT_PERF <= '0;
        BUSY     <= 1'b0;
      end
    end
  end

endmodule
